// File: rtl/bus_transfer_controller_if.sv
// Command handshake and shared-DATA-bus control signals of bus_transfer_controller.
// The master modport is the controller's view; slave is the command source and register-file side.
interface bus_transfer_controller_if #(
  parameter int NUM_REGS = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_src;
  logic [1:0]          cmd_dst;
  logic                cmd_imm_sel;
  logic [7:0]          cmd_imm;
  logic [NUM_REGS-1:0] reg_enable;
  logic [NUM_REGS-1:0] reg_latch;
  logic                bus_drive;
  logic [7:0]          bus_data;
  logic                busy;
  logic                done;
  logic                cmd_err;
  logic [7:0]          xfer_count;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_imm_sel, cmd_imm,
    output cmd_ready, reg_enable, reg_latch, bus_drive, bus_data,
           busy, done, cmd_err, xfer_count
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_imm_sel, cmd_imm,
    input  cmd_ready, reg_enable, reg_latch, bus_drive, bus_data,
           busy, done, cmd_err, xfer_count
  );
endinterface

// File: rtl/bus_transfer_controller.sv
// Sequences one register-to-register or immediate-to-register move on a shared tristate bus.
// Every output is registered: the output decode looks at the state being entered next.
module bus_transfer_controller #(
  parameter int NUM_REGS = 4
) (
  input logic                       clk,
  input logic                       reset,
  bus_transfer_controller_if.master bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;

  localparam logic [2:0] REG_LIMIT = 3'(NUM_REGS);

  state_t              state;
  state_t              next_state;
  logic [1:0]          src_q, dst_q, src_n, dst_n;
  logic                sel_q, sel_n;
  logic [7:0]          imm_q, imm_n;
  logic                handshake;
  logic                reject;
  logic                no_op;
  logic [NUM_REGS-1:0] src_oh, dst_oh;
  logic                cmd_ready_d, busy_d, done_d, cmd_err_d, bus_drive_d;
  logic [NUM_REGS-1:0] reg_enable_d, reg_latch_d;
  logic [7:0]          bus_data_d, xfer_count_d;

  assign handshake = (state == IDLE) && bus.cmd_valid;

  // The live command steers the decode on the accepting edge; the captured copy afterwards.
  always_comb begin
    if (state == IDLE) begin
      src_n = bus.cmd_src;
      dst_n = bus.cmd_dst;
      sel_n = bus.cmd_imm_sel;
      imm_n = bus.cmd_imm;
    end else begin
      src_n = src_q;
      dst_n = dst_q;
      sel_n = sel_q;
      imm_n = imm_q;
    end
  end

  assign reject = ({1'b0, dst_n} >= REG_LIMIT) ||
                  (!sel_n && ({1'b0, src_n} >= REG_LIMIT));
  assign no_op  = !sel_n && (src_n == dst_n);
  assign src_oh = {{(NUM_REGS-1){1'b0}}, 1'b1} << src_n;
  assign dst_oh = {{(NUM_REGS-1){1'b0}}, 1'b1} << dst_n;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = (reject || no_op) ? DONE : DRIVE;
      DRIVE:   next_state = LATCH;
      LATCH:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d  = (next_state == IDLE);
    busy_d       = (next_state != IDLE);
    done_d       = 1'b0;
    cmd_err_d    = 1'b0;
    bus_drive_d  = 1'b0;
    bus_data_d   = 8'd0;
    reg_enable_d = '0;
    reg_latch_d  = '0;
    xfer_count_d = bus.xfer_count;
    case (next_state)
      DRIVE, LATCH: begin
        if (sel_n) begin
          bus_drive_d = 1'b1;
          bus_data_d  = imm_n;
        end else begin
          reg_enable_d = src_oh;
        end
        if (next_state == LATCH) reg_latch_d = dst_oh;
      end
      DONE: begin
        done_d    = 1'b1;
        // Only a command rejected straight out of IDLE reaches DONE with an error.
        cmd_err_d = (state == IDLE) && reject;
        if (!cmd_err_d) xfer_count_d = bus.xfer_count + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      src_q          <= 2'd0;
      dst_q          <= 2'd0;
      sel_q          <= 1'b0;
      imm_q          <= 8'd0;
      bus.cmd_ready  <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.cmd_err    <= 1'b0;
      bus.bus_drive  <= 1'b0;
      bus.bus_data   <= 8'd0;
      bus.reg_enable <= '0;
      bus.reg_latch  <= '0;
      bus.xfer_count <= 8'd0;
    end else begin
      state <= next_state;
      if (handshake) begin
        src_q <= bus.cmd_src;
        dst_q <= bus.cmd_dst;
        sel_q <= bus.cmd_imm_sel;
        imm_q <= bus.cmd_imm;
      end
      bus.cmd_ready  <= cmd_ready_d;
      bus.busy       <= busy_d;
      bus.done       <= done_d;
      bus.cmd_err    <= cmd_err_d;
      bus.bus_drive  <= bus_drive_d;
      bus.bus_data   <= bus_data_d;
      bus.reg_enable <= reg_enable_d;
      bus.reg_latch  <= reg_latch_d;
      bus.xfer_count <= xfer_count_d;
    end
  end
endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed scoreboard bench for bus_transfer_controller: a 4-register instance for the main
// flows and a 3-register instance for out-of-range rejects.
module tb_bus_transfer_controller;
  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       drive;
    logic [3:0] en;
    logic [3:0] lat;
    logic [7:0] data;
    logic [7:0] count;
  } obs_t;

  typedef struct {
    string      name;
    bit         on3;
    logic [1:0] src;
    logic [1:0] dst;
    logic       sel;
    logic [7:0] imm;
    logic       err;
    logic [7:0] cnt_before;
    logic [7:0] cnt_after;
    int         latency;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [7:0] model_cnt [0:1];
  logic prev_done4 = 1'b0;
  logic prev_done3 = 1'b0;

  bus_transfer_controller_if #(.NUM_REGS(4)) bif  ();
  bus_transfer_controller_if #(.NUM_REGS(3)) bif3 ();

  bus_transfer_controller #(.NUM_REGS(4)) dut  (.clk(clk), .reset(reset), .bus(bif));
  bus_transfer_controller #(.NUM_REGS(3)) dut3 (.clk(clk), .reset(reset), .bus(bif3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic obs_t sample(input bit on3);
    obs_t o;
    if (on3) begin
      o.ready = bif3.cmd_ready; o.busy = bif3.busy; o.done = bif3.done;
      o.err = bif3.cmd_err; o.drive = bif3.bus_drive;
      o.en = {1'b0, bif3.reg_enable}; o.lat = {1'b0, bif3.reg_latch};
      o.data = bif3.bus_data; o.count = bif3.xfer_count;
    end else begin
      o.ready = bif.cmd_ready; o.busy = bif.busy; o.done = bif.done;
      o.err = bif.cmd_err; o.drive = bif.bus_drive;
      o.en = bif.reg_enable; o.lat = bif.reg_latch;
      o.data = bif.bus_data; o.count = bif.xfer_count;
    end
    return o;
  endfunction

  function automatic obs_t idle_obs(input logic [7:0] cnt);
    obs_t e;
    e = '0;
    e.ready = 1'b1;
    e.count = cnt;
    return e;
  endfunction

  // Expected outputs k cycles after the accepting edge of command r.
  function automatic obs_t predict(input exp_t r, input int k);
    obs_t e;
    e = '0;
    e.count = r.cnt_before;
    if (k > r.latency) begin
      e = idle_obs(r.cnt_after);
    end else if (k == r.latency) begin
      e.busy = 1'b1; e.done = 1'b1; e.err = r.err; e.count = r.cnt_after;
    end else begin
      e.busy = 1'b1;
      if (r.sel) begin e.drive = 1'b1; e.data = r.imm; end
      else e.en = oh(r.src);
      if (k == 2) e.lat = oh(r.dst);
    end
    return e;
  endfunction

  function automatic logic inv_ok(input logic [3:0] en, input logic [3:0] lat, input logic drv,
                                  input logic [7:0] data, input logic dn, input logic pdn);
    return ($countones({en, drv}) <= 1) && ($countones(lat) <= 1) &&
           (drv || (data == 8'd0)) && !(dn && pdn);
  endfunction

  always @(negedge clk) begin
    checkOutput("invariant_n4", inv_ok(bif.reg_enable, bif.reg_latch, bif.bus_drive,
                bif.bus_data, bif.done, prev_done4), 1);
    checkOutput("invariant_n3", inv_ok({1'b0, bif3.reg_enable}, {1'b0, bif3.reg_latch},
                bif3.bus_drive, bif3.bus_data, bif3.done, prev_done3), 1);
    prev_done4 <= bif.done;
    prev_done3 <= bif3.done;
  end

  // Offer one command for a single cycle and push its predicted outcome.
  task automatic applyStimulus(input string name, input bit on3, input logic [1:0] src,
                               input logic [1:0] dst, input logic sel, input logic [7:0] imm);
    exp_t r;
    obs_t o;
    int   n;
    int   w;
    w = 0;
    o = sample(on3);
    while (!o.ready && w < 10) begin
      tick();
      o = sample(on3);
      w++;
    end
    if (!o.ready) checkOutput({name, "_ready_timeout"}, 0, 1);
    if (on3) begin
      bif3.cmd_valid = 1'b1; bif3.cmd_src = src; bif3.cmd_dst = dst;
      bif3.cmd_imm_sel = sel; bif3.cmd_imm = imm;
    end else begin
      bif.cmd_valid = 1'b1; bif.cmd_src = src; bif.cmd_dst = dst;
      bif.cmd_imm_sel = sel; bif.cmd_imm = imm;
    end
    n = on3 ? 3 : 4;
    r.name = name; r.on3 = on3; r.src = src; r.dst = dst; r.sel = sel; r.imm = imm;
    r.err = (int'(dst) >= n) || (!sel && (int'(src) >= n));
    r.latency = (r.err || (!sel && (src == dst))) ? 1 : 3;
    r.cnt_before = model_cnt[on3];
    r.cnt_after = r.err ? r.cnt_before : r.cnt_before + 8'd1;
    model_cnt[on3] = r.cnt_after;
    sb.push_back(r);
    tick();
    bif.cmd_valid = 1'b0;
    bif3.cmd_valid = 1'b0;
  endtask

  task automatic checkTransfer();
    exp_t r;
    obs_t o;
    int   done_k;
    done_k = 0;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
      return;
    end
    r = sb[0];
    for (int k = 1; k <= r.latency + 1; k++) begin
      o = sample(r.on3);
      checkOutput($sformatf("%s_c%0d", r.name, k), o, predict(r, k));
      if (o.done && done_k == 0) begin
        done_k = k;
        r = sb.pop_front();
      end
      if (k <= r.latency) tick();
    end
    if (done_k == 0) r = sb.pop_front();
    checkOutput({r.name, "_latency"}, done_k, r.latency);
  endtask

  initial begin
    obs_t o;
    obs_t e;
    model_cnt[0] = 8'd0;
    model_cnt[1] = 8'd0;
    reset = 1'b1;
    bif.cmd_valid = 1'b0; bif.cmd_src = 2'd0; bif.cmd_dst = 2'd0;
    bif.cmd_imm_sel = 1'b0; bif.cmd_imm = 8'd0;
    bif3.cmd_valid = 1'b0; bif3.cmd_src = 2'd0; bif3.cmd_dst = 2'd0;
    bif3.cmd_imm_sel = 1'b0; bif3.cmd_imm = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_n4", sample(0), idle_obs(8'd0));
    checkOutput("reset_n3", sample(1), idle_obs(8'd0));

    applyStimulus("move_1_3", 0, 2'd1, 2'd3, 1'b0, 8'h00); checkTransfer();
    applyStimulus("imm_a5_0", 0, 2'd0, 2'd0, 1'b1, 8'hA5); checkTransfer();
    applyStimulus("move_3_2", 0, 2'd3, 2'd2, 1'b0, 8'hFF); checkTransfer();
    applyStimulus("imm_3c_3", 0, 2'd2, 2'd3, 1'b1, 8'h3C); checkTransfer();
    applyStimulus("noop_2_2", 0, 2'd2, 2'd2, 1'b0, 8'h11); checkTransfer();
    applyStimulus("rej_dst3", 1, 2'd1, 2'd3, 1'b0, 8'h00); checkTransfer();
    applyStimulus("rej_src3", 1, 2'd3, 2'd0, 1'b0, 8'h00); checkTransfer();
    applyStimulus("n3_imm_5a", 1, 2'd3, 2'd2, 1'b1, 8'h5A); checkTransfer();
    applyStimulus("n3_move_2_0", 1, 2'd2, 2'd0, 1'b0, 8'h00); checkTransfer();
    applyStimulus("rej_imm_dst3", 1, 2'd0, 2'd3, 1'b1, 8'h77); checkTransfer();

    // Reset lands on the LATCH cycle of an in-flight move.
    applyStimulus("move_2_0", 0, 2'd2, 2'd0, 1'b0, 8'h00);
    tick();
    o = sample(0);
    checkOutput("latch_before_reset", o.lat, oh(2'd0));
    reset = 1'b1;
    tick();
    sb.delete();
    model_cnt[0] = 8'd0;
    model_cnt[1] = 8'd0;
    checkOutput("after_reset_n4", sample(0), idle_obs(8'd0));
    checkOutput("after_reset_n3", sample(1), idle_obs(8'd0));
    bif.cmd_valid = 1'b1; bif.cmd_src = 2'd1; bif.cmd_dst = 2'd2;
    bif.cmd_imm_sel = 1'b0; bif.cmd_imm = 8'h00;
    tick();
    checkOutput("reset_handshake_dropped", sample(0), idle_obs(8'd0));
    reset = 1'b0;

    for (int k = 0; k < 12; k++) begin
      e = '0;
      e.ready = (k % 4 == 0);
      e.busy = (k % 4 != 0);
      e.en = ((k % 4 == 1) || (k % 4 == 2)) ? oh(2'd1) : 4'd0;
      e.lat = (k % 4 == 2) ? oh(2'd2) : 4'd0;
      e.done = (k % 4 == 3);
      e.count = 8'((k + 1) / 4);
      checkOutput($sformatf("b2b_c%0d", k), sample(0), e);
      tick();
    end
    bif.cmd_valid = 1'b0;
    model_cnt[0] = 8'd3;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_cnt[0] = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 1) applyStimulus("wrap_imm", 0, 2'd0, 2'(i % 4), 1'b1, 8'(i));
      else            applyStimulus("wrap_noop", 0, 2'(i % 4), 2'(i % 4), 1'b0, 8'(i));
      checkTransfer();
    end
    o = sample(0);
    checkOutput("wrap_count", o.count, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
